// File: rtl/preg_alloc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// preg_alloc_ctrl_pkg
// Shared sizing constants and index types for the physical register file
// free list. Rename, ROB and the allocator all import this package so that
// physical register numbers have a single, agreed width.
// ---------------------------------------------------------------------------
package preg_alloc_ctrl_pkg;

  localparam int PREG_W        = 6;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;

  // Free-list pointers address FL_DEPTH slots; the count needs one more bit
  // so that a completely full list (FL_DEPTH entries) is representable.
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = FL_PTR_W + 1;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_CNT_W-1:0] fl_cnt_t;

endpackage

// File: rtl/preg_free_fifo.sv
// ---------------------------------------------------------------------------
// preg_free_fifo
// Storage array for the physical register free list: one combinational read
// port and two write ports. Only the reset init pattern touches the data;
// pointers and occupancy live in the controller.
//
// Ports
//   clk_i      clock
//   reset_i    async active-high reset, loads slot i with BASE+i
//   rd_addr_i  read address (free-list head)
//   rd_data_o  entry at rd_addr_i
//   we1_i / waddr1_i / wdata1_i   write port 1
//   we2_i / waddr2_i / wdata2_i   write port 2 (never same address as port 1)
// ---------------------------------------------------------------------------
module preg_free_fifo
  import preg_alloc_ctrl_pkg::*;
#(
  parameter int DEPTH = FL_DEPTH,
  parameter int BASE  = NUM_ARCH_REGS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [PREG_W-1:0] rd_data_o,
  input  logic              we1_i,
  input  logic [AW-1:0]     waddr1_i,
  input  logic [PREG_W-1:0] wdata1_i,
  input  logic              we2_i,
  input  logic [AW-1:0]     waddr2_i,
  input  logic [PREG_W-1:0] wdata2_i
);

  logic [PREG_W-1:0] mem_q [DEPTH];

  // Reset seeds the list with the registers not mapped to architectural
  // state; afterwards the two release ports write independently.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PREG_W'(BASE + i);
      end
    end else begin
      if (we1_i) mem_q[waddr1_i] <= wdata1_i;
      if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/preg_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// preg_alloc_ctrl
// Physical register allocator. Hands out the register at the head of a
// circular free list to the rename stage and takes back up to two released
// registers per cycle from retire. A membership bitmap rejects double
// releases; a full list drops excess releases. Both events latch sticky
// error flags.
//
// Ports
//   clk_i            clock
//   reset_i          async active-high reset
//   alloc_req_i      rename wants one destination register
//   alloc_gnt_o      request granted, alloc_preg_o consumed this cycle
//   alloc_preg_o     register at the free-list head
//   rel_valid1_i/2_i retire release ports
//   rel_preg1_i/2_i  registers being released
//   free_count_o     registered number of free registers
//   empty_o          registered free_count == 0
//   stall_o          alloc_req_i && !alloc_gnt_o
//   overflow_err_o   sticky: release dropped because the list was full
//   dup_err_o        sticky: release of a register that was already free
// ---------------------------------------------------------------------------
module preg_alloc_ctrl
  import preg_alloc_ctrl_pkg::*;
#(
  parameter int NUM_PHYS_REGS = preg_alloc_ctrl_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = preg_alloc_ctrl_pkg::NUM_ARCH_REGS,
  parameter int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [PREG_W-1:0] alloc_preg_o,
  input  logic              rel_valid1_i,
  input  logic [PREG_W-1:0] rel_preg1_i,
  input  logic              rel_valid2_i,
  input  logic [PREG_W-1:0] rel_preg2_i,
  output logic [PREG_W-1:0] free_count_o,
  output logic              empty_o,
  output logic              stall_o,
  output logic              overflow_err_o,
  output logic              dup_err_o
);

  localparam int PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [NUM_PHYS_REGS-1:0] inFree_q, inFree_d;
  logic                     empty_q;
  logic                     overflow_q;
  logic                     dup_q;

  logic              allocGnt;
  logic [CNT_W-1:0]  countAfterAlloc;
  logic [CNT_W-1:0]  room;
  logic              dup1, dup2, acc1, acc2, dropFull;
  logic              we1, we2;
  logic [PREG_W-1:0] wdata1;
  logic [PREG_W-1:0] headPreg;

  preg_free_fifo #(
    .DEPTH (FL_DEPTH),
    .BASE  (NUM_ARCH_REGS),
    .AW    (PTR_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rd_addr_i (head_q),
    .rd_data_o (headPreg),
    .we1_i     (we1),
    .waddr1_i  (tail_q),
    .wdata1_i  (wdata1),
    .we2_i     (we2),
    .waddr2_i  (tail_q + PTR_W'(1)),
    .wdata2_i  (rel_preg2_i)
  );

  // Grant, release acceptance and next state. Capacity is judged after the
  // same-cycle allocation frees its slot, so an allocation and two releases
  // can all land together. Port 1 has priority for the last free slot, and
  // a port-2 release naming the same register as port 1 counts as a
  // duplicate. Releases only reach the list on the next edge, so a register
  // released while empty is never granted in the same cycle.
  always_comb begin
    allocGnt        = alloc_req_i && (count_q != '0);
    countAfterAlloc = count_q - CNT_W'(allocGnt);
    room            = CNT_W'(FL_DEPTH) - countAfterAlloc;

    dup1 = rel_valid1_i && inFree_q[rel_preg1_i];
    acc1 = rel_valid1_i && !dup1 && (room != '0);
    dup2 = rel_valid2_i && (inFree_q[rel_preg2_i] ||
           (rel_valid1_i && (rel_preg1_i == rel_preg2_i)));
    acc2 = rel_valid2_i && !dup2 && (room > CNT_W'(acc1));
    dropFull = (rel_valid1_i && !dup1 && !acc1) ||
               (rel_valid2_i && !dup2 && !acc2);

    // A lone port-2 release still goes to the tail slot.
    we1    = acc1 || acc2;
    we2    = acc1 && acc2;
    wdata1 = acc1 ? rel_preg1_i : rel_preg2_i;

    head_d  = head_q + PTR_W'(allocGnt);
    tail_d  = tail_q + PTR_W'(acc1) + PTR_W'(acc2);
    count_d = countAfterAlloc + CNT_W'(acc1) + CNT_W'(acc2);

    inFree_d = inFree_q;
    if (allocGnt) inFree_d[headPreg]    = 1'b0;
    if (acc1)     inFree_d[rel_preg1_i] = 1'b1;
    if (acc2)     inFree_d[rel_preg2_i] = 1'b1;
  end

  // All state resets asynchronously, so an edge that coincides with reset
  // commits nothing from in-flight requests.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(FL_DEPTH);
      empty_q    <= 1'b0;
      overflow_q <= 1'b0;
      dup_q      <= 1'b0;
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        inFree_q[i] <= (i >= NUM_ARCH_REGS) && (i < NUM_ARCH_REGS + FL_DEPTH);
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inFree_q   <= inFree_d;
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_q || dropFull;
      dup_q      <= dup_q || dup1 || dup2;
    end
  end

  assign alloc_gnt_o    = allocGnt;
  assign alloc_preg_o   = headPreg;
  assign stall_o        = alloc_req_i && !allocGnt;
  assign free_count_o   = PREG_W'(count_q);
  assign empty_o        = empty_q;
  assign overflow_err_o = overflow_q;
  assign dup_err_o      = dup_q;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_preg_alloc_ctrl
// Self-checking bench for preg_alloc_ctrl. A queue-based model of the free
// list predicts every output each cycle; directed literal checks pin the
// model on the key scenarios (drain order, empty release, dual release with
// allocation, overflow, duplicates, mid-stream reset).
// ---------------------------------------------------------------------------
module tb_preg_alloc_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       alloc_req_i;
  logic       alloc_gnt_o;
  logic [5:0] alloc_preg_o;
  logic       rel_valid1_i, rel_valid2_i;
  logic [5:0] rel_preg1_i, rel_preg2_i;
  logic [5:0] free_count_o;
  logic       empty_o, stall_o, overflow_err_o, dup_err_o;

  int errorCount = 0;
  int checkCount = 0;

  // Model state: free registers in FIFO order, membership, sticky errors.
  int modelQ[$];
  bit modelFree[64];
  bit modelOvf;
  bit modelDup;

  preg_alloc_ctrl dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .alloc_req_i    (alloc_req_i),
    .alloc_gnt_o    (alloc_gnt_o),
    .alloc_preg_o   (alloc_preg_o),
    .rel_valid1_i   (rel_valid1_i),
    .rel_preg1_i    (rel_preg1_i),
    .rel_valid2_i   (rel_valid2_i),
    .rel_preg2_i    (rel_preg2_i),
    .free_count_o   (free_count_o),
    .empty_o        (empty_o),
    .stall_o        (stall_o),
    .overflow_err_o (overflow_err_o),
    .dup_err_o      (dup_err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic checkEq(input string name, input logic [31:0] act, input int exp);
    checkCount++;
    if (act !== 32'(exp)) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    for (int i = 0; i < 32; i++) modelQ.push_back(32 + i);
    for (int i = 0; i < 64; i++) modelFree[i] = (i >= 32);
    modelOvf = 1'b0;
    modelDup = 1'b0;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic checkOutput();
    int sz;
    bit expGnt;
    sz     = modelQ.size();
    expGnt = alloc_req_i && (sz > 0);
    checkEq("alloc_gnt", alloc_gnt_o, int'(expGnt));
    checkEq("stall", stall_o, int'(alloc_req_i && !expGnt));
    checkEq("free_count", free_count_o, sz);
    checkEq("empty", empty_o, int'(sz == 0));
    checkEq("overflow_err", overflow_err_o, int'(modelOvf));
    checkEq("dup_err", dup_err_o, int'(modelDup));
    if (sz > 0) checkEq("alloc_preg", alloc_preg_o, modelQ[0]);
  endtask

  // Advance the model by one clock edge using the driven inputs.
  task automatic modelStep();
    bit freeBefore[64];
    int p1, p2, popped;
    freeBefore = modelFree;
    p1 = int'(rel_preg1_i);
    p2 = int'(rel_preg2_i);
    if (alloc_req_i && modelQ.size() > 0) begin
      popped = modelQ.pop_front();
      modelFree[popped] = 1'b0;
    end
    if (rel_valid1_i) begin
      if (freeBefore[p1]) modelDup = 1'b1;
      else if (modelQ.size() < 32) begin
        modelQ.push_back(p1);
        modelFree[p1] = 1'b1;
      end else modelOvf = 1'b1;
    end
    if (rel_valid2_i) begin
      if ((rel_valid1_i && p2 == p1) || freeBefore[p2]) modelDup = 1'b1;
      else if (modelQ.size() < 32) begin
        modelQ.push_back(p2);
        modelFree[p2] = 1'b1;
      end else modelOvf = 1'b1;
    end
  endtask

  // Drive one cycle's inputs at the falling edge and check the outputs;
  // the caller may add literal checks before calling tick().
  task automatic applyStimulus(input bit req, input bit v1, input int p1,
                               input bit v2, input int p2);
    @(negedge clk_i);
    alloc_req_i  = req;
    rel_valid1_i = v1;
    rel_preg1_i  = 6'(p1);
    rel_valid2_i = v2;
    rel_preg2_i  = 6'(p2);
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk_i);
    modelStep();
  endtask

  task automatic cycle(input bit req, input bit v1, input int p1,
                       input bit v2, input int p2);
    applyStimulus(req, v1, p1, v2, p2);
    tick();
  endtask

  task automatic doReset();
    @(negedge clk_i);
    reset_i      = 1'b1;
    alloc_req_i  = 1'b0;
    rel_valid1_i = 1'b0;
    rel_valid2_i = 1'b0;
    modelReset();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i      = 1'b1;
    alloc_req_i  = 1'b0;
    rel_valid1_i = 1'b0;
    rel_valid2_i = 1'b0;
    rel_preg1_i  = '0;
    rel_preg2_i  = '0;
    modelReset();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("reset alloc_preg", alloc_preg_o, 32);
    checkEq("reset free_count", free_count_o, 32);
    checkEq("reset empty", empty_o, 0);
    tick();

    // Drain: 32..63 in order, then stall on empty
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkEq("drain order", alloc_preg_o, 32 + i);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkEq("empty gnt", alloc_gnt_o, 0);
    checkEq("empty stall", stall_o, 1);
    checkEq("empty flag", empty_o, 1);
    tick();

    // Release while empty: no bypass, granted next cycle
    applyStimulus(1, 1, 5, 0, 0);
    checkEq("no bypass stall", stall_o, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    checkEq("late gnt", alloc_gnt_o, 1);
    checkEq("late preg", alloc_preg_o, 5);
    checkEq("late count", free_count_o, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("late drain count", free_count_o, 0);
    tick();

    // Build count=10 (including a lone port-2 release), then alloc + 7,9
    cycle(0, 0, 0, 1, 32);
    cycle(0, 1, 33, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 34 + 2 * k, 1, 35 + 2 * k);
    applyStimulus(1, 1, 7, 1, 9);
    checkEq("c10 count", free_count_o, 10);
    checkEq("c10 head", alloc_preg_o, 32);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("c11 count", free_count_o, 11);
    checkEq("c11 ovf", overflow_err_o, 0);
    checkEq("c11 dup", dup_err_o, 0);
    tick();
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkEq("order 7", alloc_preg_o, 7);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    checkEq("order 9", alloc_preg_o, 9);
    tick();

    // Full with grant: one slot left, port 1 wins
    doReset();
    applyStimulus(1, 1, 3, 1, 4);
    checkEq("full gnt", alloc_gnt_o, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("full ovf", overflow_err_o, 1);
    checkEq("full count", free_count_o, 32);
    checkEq("full dup", dup_err_o, 0);
    tick();
    for (int i = 0; i < 31; i++) cycle(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkEq("full tail 3", alloc_preg_o, 3);
    tick();

    // Duplicate release of an already-free register
    doReset();
    cycle(0, 1, 40, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("dup40 flag", dup_err_o, 1);
    checkEq("dup40 count", free_count_o, 32);
    tick();

    // Full without grant drops both; identical pair keeps port 1 only
    doReset();
    cycle(0, 1, 1, 1, 2);
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("both drop ovf", overflow_err_o, 1);
    checkEq("both drop count", free_count_o, 32);
    tick();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 12, 1, 12);
    applyStimulus(0, 0, 0, 0, 0);
    checkEq("pair count", free_count_o, 31);
    checkEq("pair dup", dup_err_o, 1);
    tick();

    // Mixed traffic against the model
    for (int i = 0; i < 80; i++) begin
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 63)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 63)));
    end

    // Mid-stream reset after 20 grants with errors set
    doReset();
    cycle(0, 1, 40, 0, 0);
    cycle(0, 1, 1, 1, 2);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 1, 4);
    #1 reset_i = 1'b1;
    #1;
    checkEq("mid reset count", free_count_o, 32);
    checkEq("mid reset preg", alloc_preg_o, 32);
    checkEq("mid reset ovf", overflow_err_o, 0);
    checkEq("mid reset dup", dup_err_o, 0);
    modelReset();
    @(negedge clk_i);
    alloc_req_i  = 1'b0;
    rel_valid1_i = 1'b0;
    rel_valid2_i = 1'b0;
    reset_i      = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    checkEq("post reset preg", alloc_preg_o, 32);
    checkEq("post reset count", free_count_o, 32);
    tick();
    cycle(1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/preg_alloc_ctrl.md
PREG_ALLOC_CTRL -- requirements
Module: preg_alloc_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHYS_REGS, default 64, total physical registers.
REQ-002 SHALL have parameter NUM_ARCH_REGS, default 32, architectural registers; physical registers 0..31 are mapped at reset.
REQ-003 SHALL have parameter FL_DEPTH, default NUM_PHYS_REGS-NUM_ARCH_REGS (32), free-FIFO capacity.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 alloc_req  in  1  rename stage requests one destination physical register this cycle.
REQ-007 alloc_gnt  out  1  request granted; alloc_preg valid and consumed this cycle.
REQ-008 alloc_preg  out  6  physical register at FIFO head.
REQ-009 rel_valid1 / rel_valid2  in  1 each  retire port 1/2 releases a physical register.
REQ-010 rel_preg1 / rel_preg2  in  6 each  physical register being released.
REQ-011 free_count  out  6  registered number of free registers, 0..32.
REQ-012 empty  out  1  free_count == 0.
REQ-013 stall  out  1  alloc_req && !alloc_gnt.
REQ-014 overflow_err  out  1  sticky; a release was dropped because the FIFO was full.
REQ-015 dup_err  out  1  sticky; a register already free was released again.

Function
REQ-016 Free list SHALL be a circular FIFO of FL_DEPTH 6-bit entries with 5-bit head, 5-bit tail and 6-bit count; pointers wrap 31->0.
REQ-017 alloc_preg SHALL equal fifo[head] combinationally from registered state; alloc_gnt = alloc_req && count != 0; zero added latency.
REQ-018 On a clock edge with alloc_gnt, head SHALL advance by 1 and the in_free bit of alloc_preg SHALL clear.
REQ-019 No bypass: a release in cycle N SHALL NOT be grantable before cycle N+1, even when empty.
REQ-020 Release writes: rel1 alone -> fifo[tail], tail+1; rel2 alone -> fifo[tail], tail+1; both -> rel1 at tail, rel2 at tail+1, tail+2.
REQ-021 count_next SHALL = count - alloc_gnt + accepted releases; alloc and releases in the same cycle are all honoured.
REQ-022 Capacity check SHALL use count - alloc_gnt: if only one slot remains, rel1 is accepted and rel2 dropped; if none, both dropped; any drop sets overflow_err.
REQ-023 A 64-bit in_free bitmap SHALL track membership; a release whose in_free bit is already set SHALL be dropped and set dup_err.
REQ-024 rel_preg1 == rel_preg2 with both valid: rel1 accepted, rel2 dropped, dup_err set.
REQ-025 free_count, empty, overflow_err and dup_err SHALL be registered; stall, alloc_gnt and alloc_preg combinational.

Reset
REQ-026 On reset assertion, asynchronously: fifo[i] = 32+i for i = 0..31, head = 0, tail = 0, count = 32, in_free[63:32] = 1, in_free[31:0] = 0, errors = 0.
REQ-027 After reset: free_count = 32, empty = 0, alloc_preg = 32; alloc_gnt follows alloc_req.
REQ-028 Reset mid-operation SHALL discard all in-flight allocations and releases; no partial update on the release edge.

Structure
REQ-029 Shared package SHALL hold PREG_W = 6, NUM_PHYS_REGS, NUM_ARCH_REGS, FL_DEPTH and the preg index type, shared with rename and ROB.
REQ-030 Storage SHALL be sub-module preg_free_fifo: 1 read port, 2 write ports, no reset on data except the init pattern.
REQ-031 Pointer, count, bitmap and error logic SHALL stay in preg_alloc_ctrl.

Verification
REQ-032 Reset, alloc_req held 32 cycles -> alloc_preg 32,33,...,63 in order; cycle 33 alloc_gnt=0, stall=1, empty=1.
REQ-033 Empty, release 5 in cycle N with alloc_req held -> stall in N, grant of 5 in N+1, free_count 0->1->0.
REQ-034 count=10, alloc plus dual release of 7 and 9 in one cycle -> free_count 11, FIFO order ...,7,9, no errors.
REQ-035 Full (count 32), dual release 3 and 4 with alloc_gnt -> 3 accepted, 4 dropped, overflow_err=1, free_count 32.
REQ-036 Release 40 right after reset -> dropped, dup_err=1, free_count stays 32.
REQ-037 Reset asserted mid-stream after 20 grants -> next cycle free_count 32, alloc_preg 32, errors cleared.
